// File: rtl/rpsc_interlock_filter.sv
// Interlock input conditioning: 2-flop sync, per-channel debounce, OK/TRIP/HOLD alarm FSM.
// Optional first-fault capture register is built only when RPSC_FIRST_FAULT_EN is defined.
module rpsc_interlock_filter #(
  parameter int          N_CH     = 8,
  parameter logic [15:0] DEB_CNT  = 16'd7813,
  parameter logic [15:0] HOLD_CYC = 16'd781
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  input  logic            ack,
  output logic [N_CH-1:0] filt_out,
  output logic [N_CH-1:0] fault_latched,
  output logic [N_CH-1:0] first_fault,
  output logic            not_alarm,
  output logic            trip_pulse
);

  typedef enum logic [1:0] {ST_OK, ST_TRIP, ST_HOLD} state_t;

  localparam logic [15:0] DEB_LAST  = DEB_CNT - 16'd1;
  localparam logic [15:0] HOLD_LAST = HOLD_CYC - 16'd1;

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] filt_q, filt_d;
  logic [15:0]     cnt_q [N_CH];
  logic [15:0]     cnt_d [N_CH];
  state_t          state_q, state_d;
  logic [15:0]     hold_q, hold_d;
  logic [N_CH-1:0] latch_q, latch_d;
  logic            not_alarm_q, trip_pulse_q;
  logic            trip_entry;

  // Synchronizer stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce stage: filtered level flips only after DEB_CNT consecutive mismatching clocks
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == DEB_LAST) filt_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_q <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Alarm FSM next-state
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_OK: begin
        if (|filt_q) state_d = ST_TRIP;
      end
      ST_TRIP: begin
        if (ack && (filt_q == '0)) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (|filt_q)                  state_d = ST_TRIP;
        else if (hold_q == HOLD_LAST) state_d = ST_OK;
        else                          hold_d  = hold_q + 16'd1;
      end
      default: state_d = ST_OK;
    endcase
  end

  assign trip_entry = (state_d == ST_TRIP) && (state_q != ST_TRIP);

  always_comb begin
    latch_d = latch_q;
    if ((state_q == ST_HOLD) && (state_d == ST_OK))
      latch_d = '0;
    else if ((state_q == ST_TRIP) || (state_d == ST_TRIP))
      latch_d = latch_q | filt_q;
  end

  // Output register stage: flags reflect the state being entered this clock
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_OK;
      hold_q       <= '0;
      latch_q      <= '0;
      not_alarm_q  <= 1'b1;
      trip_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      latch_q      <= latch_d;
      not_alarm_q  <= (state_d == ST_OK);
      trip_pulse_q <= trip_entry;
    end
  end

`ifdef RPSC_FIRST_FAULT_EN
  logic [N_CH-1:0] first_q;

  always_ff @(posedge clk) begin
    if (!reset)          first_q <= '0;
    else if (trip_entry) first_q <= filt_q;
  end

  assign first_fault = first_q;
`else
  assign first_fault = '0;
`endif

  assign filt_out      = filt_q;
  assign fault_latched = latch_q;
  assign not_alarm     = not_alarm_q;
  assign trip_pulse    = trip_pulse_q;

endmodule

// File: tb/tb_rpsc_interlock_filter.sv
// Directed bench for rpsc_interlock_filter with DEB_CNT=4, HOLD_CYC=3, N_CH=8.
module tb_rpsc_interlock_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] raw_in;
  logic       ack;
  logic [7:0] filt_out, fault_latched, first_fault;
  logic       not_alarm, trip_pulse;

  int checks = 0;
  int errors = 0;

  rpsc_interlock_filter #(
    .N_CH    (8),
    .DEB_CNT (16'd4),
    .HOLD_CYC(16'd3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_in       (raw_in),
    .ack          (ack),
    .filt_out     (filt_out),
    .fault_latched(fault_latched),
    .first_fault  (first_fault),
    .not_alarm    (not_alarm),
    .trip_pulse   (trip_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] ff_exp(input logic [7:0] v);
`ifdef RPSC_FIRST_FAULT_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  initial begin
    reset  = 1'b0;
    raw_in = 8'h00;
    ack    = 1'b0;
    step(2);
    check("rst_filt", 16'(filt_out), 16'h00);
    check("rst_latch", 16'(fault_latched), 16'h00);
    check("rst_first", 16'(first_fault), 16'h00);
    check("rst_notalarm", 16'(not_alarm), 16'h1);
    check("rst_pulse", 16'(trip_pulse), 16'h0);
    reset = 1'b1;
    step(1);

    // Single channel trip: filt at +6, pulse/latch at +7
    raw_in = 8'h01;
    step(5);
    check("t1_filt_early", 16'(filt_out), 16'h00);
    step(1);
    check("t1_filt", 16'(filt_out), 16'h01);
    check("t1_notalarm_pre", 16'(not_alarm), 16'h1);
    step(1);
    check("t1_pulse", 16'(trip_pulse), 16'h1);
    check("t1_notalarm", 16'(not_alarm), 16'h0);
    check("t1_latch", 16'(fault_latched), 16'h01);
    check("t1_first", 16'(first_fault), 16'(ff_exp(8'h01)));
    step(1);
    check("t1_pulse_end", 16'(trip_pulse), 16'h0);

    // Second channel joins, ack ignored while faults active
    raw_in = 8'h21;
    step(7);
    check("t2_filt", 16'(filt_out), 16'h21);
    check("t2_latch", 16'(fault_latched), 16'h21);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("t2_ack_ignored", 16'(not_alarm), 16'h0);
    raw_in = 8'h00;
    step(6);
    check("t2_filt_clear", 16'(filt_out), 16'h00);
    step(1);
    check("t2_no_queue", 16'(not_alarm), 16'h0);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("t2_hold1", 16'(not_alarm), 16'h0);
    check("t2_hold_latch", 16'(fault_latched), 16'h21);
    step(2);
    check("t2_hold3", 16'(not_alarm), 16'h0);
    step(1);
    check("t2_ok", 16'(not_alarm), 16'h1);
    check("t2_latch_clr", 16'(fault_latched), 16'h00);
    check("t2_first_kept", 16'(first_fault), 16'(ff_exp(8'h01)));

    // Glitch of 3 clocks must not pass the debounce
    raw_in = 8'h04;
    step(3);
    raw_in = 8'h00;
    step(8);
    check("t3_glitch_filt", 16'(filt_out), 16'h00);
    check("t3_glitch_ok", 16'(not_alarm), 16'h1);

    // Simultaneous channels recorded together
    raw_in = 8'h0A;
    step(6);
    check("t4_filt", 16'(filt_out), 16'h0A);
    step(1);
    check("t4_pulse", 16'(trip_pulse), 16'h1);
    check("t4_first", 16'(first_fault), 16'(ff_exp(8'h0A)));
    check("t4_latch", 16'(fault_latched), 16'h0A);

    // Fault arriving in HOLD clock 2 re-enters TRIP
    raw_in = 8'h00;
    step(6);
    check("t5_filt_clear", 16'(filt_out), 16'h00);
    raw_in = 8'h10;
    step(4);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("t5_hold_entry", 16'(not_alarm), 16'h0);
    step(1);
    check("t5_filt_hold2", 16'(filt_out), 16'h10);
    check("t5_no_pulse_yet", 16'(trip_pulse), 16'h0);
    step(1);
    check("t5_retrip_pulse", 16'(trip_pulse), 16'h1);
    check("t5_retrip_first", 16'(first_fault), 16'(ff_exp(8'h10)));
    check("t5_retrip_latch", 16'(fault_latched), 16'h1A);
    raw_in = 8'h00;
    step(6);
    check("t5_filt_clear2", 16'(filt_out), 16'h00);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(2);
    check("t5_full_hold", 16'(not_alarm), 16'h0);
    step(1);
    check("t5_ok", 16'(not_alarm), 16'h1);
    check("t5_latch_clr", 16'(fault_latched), 16'h00);

    // Reset during TRIP, then re-trip from an input already high
    raw_in = 8'h80;
    step(7);
    check("t6_pulse", 16'(trip_pulse), 16'h1);
    check("t6_notalarm", 16'(not_alarm), 16'h0);
    reset = 1'b0;
    step(1);
    check("t6_rst_notalarm", 16'(not_alarm), 16'h1);
    check("t6_rst_filt", 16'(filt_out), 16'h00);
    check("t6_rst_latch", 16'(fault_latched), 16'h00);
    check("t6_rst_first", 16'(first_fault), 16'h00);
    check("t6_rst_pulse", 16'(trip_pulse), 16'h0);
    reset = 1'b1;
    step(5);
    check("t7_filt_early", 16'(filt_out), 16'h00);
    step(1);
    check("t7_filt", 16'(filt_out), 16'h80);
    step(1);
    check("t7_pulse", 16'(trip_pulse), 16'h1);
    check("t7_latch", 16'(fault_latched), 16'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
